// File: rtl/beam_drive_ctrl.sv
// Wheel stepper sequencer for the beam-following bot: input filtering,
// track/search/lost FSM and an accelerating shared phase counter.
module beam_drive_ctrl #(
    parameter logic [15:0]     DEB_COUNT    = 16'd50000,
    parameter int              STEP_W       = 20,
    parameter logic [STEP_W-1:0] PERIOD_START = 20'd262143,
    parameter logic [STEP_W-1:0] PERIOD_MIN   = 20'd131071,
    parameter logic [STEP_W-1:0] RAMP_DEC     = 20'd1024,
    parameter logic [9:0]      LOST_STEPS   = 10'd512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       beam_l,
    input  logic       beam_r,
    input  logic       man_l,
    input  logic       man_r,
    output logic       en_l,
    output logic       en_r,
    output logic       dir_l,
    output logic       dir_r,
    output logic [2:0] phase,
    output logic [1:0] state,
    output logic       lost
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] SEARCH = 2'd2;
    localparam logic [1:0] LOST   = 2'd3;

    localparam logic [STEP_W-1:0] ONE = 1;

    logic [3:0]        s1;
    logic [3:0]        s2;
    logic [1:0]        flt;
    logic [15:0]       dc [2];
    logic [1:0]        st;
    logic [1:0]        nxt;
    logic              last_l;
    logic [9:0]        steps;
    logic [STEP_W-1:0] cur;
    logic [STEP_W-1:0] cnt;
    logic [STEP_W-1:0] ramp;
    logic              any;
    logic              man;
    logic              restart;
    logic              en_any;
    logic              tick;

    assign state   = st;
    assign any     = |flt;
    assign man     = s2[2] | s2[3];
    assign en_any  = en_l | en_r;
    assign restart = (st == TRACK && nxt == SEARCH) ||
                     (st == SEARCH && nxt == TRACK);
    assign tick    = en_any && (cnt == '0) && !restart;
    // Saturating ramp; subtract only when it cannot pass PERIOD_MIN
    assign ramp    = (cur - PERIOD_MIN >= RAMP_DEC) ? cur - RAMP_DEC
                                                    : PERIOD_MIN;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            flt   <= '0;
            dc[0] <= '0;
            dc[1] <= '0;
        end else begin
            s1 <= {man_r, man_l, beam_r, beam_l};
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] != flt[i]) begin
                    if (dc[i] == DEB_COUNT - 16'd1) begin
                        flt[i] <= ~flt[i];
                        dc[i]  <= '0;
                    end else begin
                        dc[i] <= dc[i] + 16'd1;
                    end
                end else begin
                    dc[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    if (any || man) nxt = TRACK;
            TRACK:   if (!any && !man) nxt = SEARCH;
            SEARCH: begin
                if (any || man) nxt = TRACK;
                else if (steps >= LOST_STEPS) nxt = LOST;
            end
            default: if (any || man) nxt = TRACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= IDLE;
            last_l <= 1'b0;
            steps  <= '0;
            en_l   <= 1'b0;
            en_r   <= 1'b0;
            dir_l  <= 1'b1;
            dir_r  <= 1'b1;
            lost   <= 1'b0;
            phase  <= '0;
            cur    <= PERIOD_START;
            cnt    <= PERIOD_START;
        end else begin
            st <= nxt;

            if (st == TRACK && flt == 2'b01) last_l <= 1'b1;
            else if (st == TRACK && flt == 2'b10) last_l <= 1'b0;

            if (st != SEARCH && nxt == SEARCH) steps <= '0;
            else if (st == SEARCH && tick) steps <= steps + 10'd1;

            case (st)
                TRACK: begin
                    en_l  <= flt[0] | s2[2];
                    en_r  <= flt[1] | s2[3];
                    dir_l <= 1'b1;
                    dir_r <= 1'b1;
                    lost  <= 1'b0;
                end
                SEARCH: begin
                    en_l  <= 1'b1;
                    en_r  <= 1'b1;
                    dir_l <= ~last_l;
                    dir_r <= last_l;
                    lost  <= 1'b0;
                end
                LOST: begin
                    en_l  <= 1'b0;
                    en_r  <= 1'b0;
                    dir_l <= 1'b1;
                    dir_r <= 1'b1;
                    lost  <= 1'b1;
                end
                default: begin
                    en_l  <= 1'b0;
                    en_r  <= 1'b0;
                    dir_l <= 1'b1;
                    dir_r <= 1'b1;
                    lost  <= 1'b0;
                end
            endcase

            // Direction reversal or idle motors restart the ramp
            if (restart || !en_any) begin
                cur <= PERIOD_START;
                cnt <= PERIOD_START;
            end else if (tick) begin
                cur   <= ramp;
                cnt   <= ramp;
                phase <= phase + 3'd1;
            end else begin
                cnt <= cnt - ONE;
            end
        end
    end

endmodule

// File: tb/tb_beam_drive_ctrl.sv
// Bench for beam_drive_ctrl: directed scenarios plus random inputs,
// checked every cycle against an event-timed reference model.
module tb_beam_drive_ctrl;

    localparam int DEB   = 4;
    localparam int START = 16;
    localparam int PMIN  = 4;
    localparam int DEC   = 4;
    localparam int LSTEP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       beam_l;
    logic       beam_r;
    logic       man_l;
    logic       man_r;
    logic       en_l;
    logic       en_r;
    logic       dir_l;
    logic       dir_r;
    logic [2:0] phase;
    logic [1:0] state;
    logic       lost;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    int m_n = 0;
    int m_state, m_last, m_steps;
    int m_en_l, m_en_r, m_dir_l, m_dir_r, m_lost;
    int m_phase, m_per, m_due;
    int m_f[2], m_run[2];
    int p1[4], p2[4];

    int found, k, ntick, en_t, last_t, saw_lost, lost_phase, gap;
    int gaps[$];
    int tphase[$];
    int exp_gaps[9] = '{17, 13, 9, 5, 5, 5, 5, 5, 5};
    logic [2:0] pp;
    int rate;

    beam_drive_ctrl #(
        .DEB_COUNT   (16'd4),
        .STEP_W      (20),
        .PERIOD_START(20'd16),
        .PERIOD_MIN  (20'd4),
        .RAMP_DEC    (20'd4),
        .LOST_STEPS  (10'd8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .beam_l(beam_l),
        .beam_r(beam_r),
        .man_l (man_l),
        .man_r (man_r),
        .en_l  (en_l),
        .en_r  (en_r),
        .dir_l (dir_l),
        .dir_r (dir_r),
        .phase (phase),
        .state (state),
        .lost  (lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_last = 0; m_steps = 0;
        m_en_l = 0; m_en_r = 0; m_dir_l = 1; m_dir_r = 1; m_lost = 0;
        m_phase = 0; m_per = START; m_due = 0;
        m_f = '{0, 0}; m_run = '{0, 0};
        p1 = '{0, 0, 0, 0}; p2 = '{0, 0, 0, 0};
    endtask

    // One clock edge of the behavioural model, all rules from old values
    task automatic model_step();
        int raw[4];
        int any, man, nx, rs, enp, tk;
        raw = '{int'(beam_l), int'(beam_r), int'(man_l), int'(man_r)};
        m_n++;
        if (reset) begin
            model_reset();
        end else begin
            any = m_f[0] | m_f[1];
            man = p2[2] | p2[3];
            if (any || man) nx = 1;
            else if (m_state == 1) nx = 2;
            else if (m_state == 2 && m_steps >= LSTEP) nx = 3;
            else nx = m_state;
            rs  = ((m_state == 1 && nx == 2) || (m_state == 2 && nx == 1)) ? 1 : 0;
            enp = m_en_l | m_en_r;
            tk  = (enp && !rs && m_n == m_due) ? 1 : 0;
            // next step edge is scheduled as an absolute cycle number
            if (rs || !enp) begin
                m_per = START;
                m_due = m_n + START + 1;
            end else if (tk) begin
                m_phase = (m_phase + 1) % 8;
                m_per   = (m_per - DEC < PMIN) ? PMIN : m_per - DEC;
                m_due   = m_n + m_per + 1;
            end
            if (m_state != 2 && nx == 2) m_steps = 0;
            else if (m_state == 2 && tk) m_steps++;
            case (m_state)
                1: begin
                    m_en_l = m_f[0] | p2[2]; m_en_r = m_f[1] | p2[3];
                    m_dir_l = 1; m_dir_r = 1; m_lost = 0;
                end
                2: begin
                    m_en_l = 1; m_en_r = 1;
                    m_dir_l = 1 - m_last; m_dir_r = m_last; m_lost = 0;
                end
                3: begin
                    m_en_l = 0; m_en_r = 0; m_dir_l = 1; m_dir_r = 1; m_lost = 1;
                end
                default: begin
                    m_en_l = 0; m_en_r = 0; m_dir_l = 1; m_dir_r = 1; m_lost = 0;
                end
            endcase
            if (m_state == 1 && m_f[0] == 1 && m_f[1] == 0) m_last = 1;
            if (m_state == 1 && m_f[1] == 1 && m_f[0] == 0) m_last = 0;
            for (int i = 0; i < 2; i++) begin
                if (p2[i] != m_f[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_f[i] = 1 - m_f[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            p2 = p1;
            p1 = raw;
            m_state = nx;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("state", 32'(state), m_state);
        chk("en_l", 32'(en_l), m_en_l);
        chk("en_r", 32'(en_r), m_en_r);
        chk("dir_l", 32'(dir_l), m_dir_l);
        chk("dir_r", 32'(dir_r), m_dir_r);
        chk("lost", 32'(lost), m_lost);
        chk("phase", 32'(phase), m_phase);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_en_l"}, 32'(en_l), 0);
        chk({tag, "_en_r"}, 32'(en_r), 0);
        chk({tag, "_dir_l"}, 32'(dir_l), 1);
        chk({tag, "_dir_r"}, 32'(dir_r), 1);
        chk({tag, "_phase"}, 32'(phase), 0);
        chk({tag, "_lost"}, 32'(lost), 0);
    endtask

    initial begin
        model_reset();
        reset = 1'b1; beam_l = 1'b1; beam_r = 1'b1;
        man_l = 1'b0; man_r = 1'b0;

        // reset with beams high, then 2+4+1 cycles to TRACK
        repeat (3) cyc();
        chk_reset_vals("rst");
        reset = 1'b0;
        found = 0; k = 0;
        for (int i = 1; i <= 20 && found == 0; i++) begin
            cyc();
            if (state == 2'd1) begin found = 1; k = i; end
        end
        chk("trk_latency", k, 7);

        // ramp with both beams steady
        en_t = -1; last_t = 0; ntick = 0; pp = phase;
        for (int i = 1; i <= 300 && ntick < 9; i++) begin
            cyc();
            if (en_t < 0 && en_l) begin en_t = i; last_t = i; end
            if (phase != pp) begin
                gaps.push_back(i - last_t);
                tphase.push_back(int'(phase));
                last_t = i; ntick++; pp = phase;
            end
        end
        chk("ramp_ticks", ntick, 9);
        for (int i = 0; i < gaps.size(); i++) chk("ramp_gap", gaps[i], exp_gaps[i]);
        if (tphase.size() == 9) begin
            chk("ramp_ph7", tphase[6], 7);
            chk("ramp_wrap", tphase[7], 0);
        end

        // left beam only, then lose both -> SEARCH turning left
        beam_r = 1'b0;
        repeat (10) cyc();
        beam_l = 1'b0;
        found = 0;
        for (int i = 1; i <= 20 && found == 0; i++) begin
            cyc();
            if (m_state == 2) found = 1;
        end
        chk("search_entry", found, 1);
        cyc();
        chk("search_dir_l", 32'(dir_l), 0);
        chk("search_dir_r", 32'(dir_r), 1);
        ntick = 0; found = 0; pp = phase;
        for (int i = 1; i <= 400 && found == 0; i++) begin
            cyc();
            if (phase != pp) begin ntick++; pp = phase; end
            if (state == 2'd3) found = 1;
        end
        chk("lost_reached", found, 1);
        chk("lost_ticks", ntick, 8);
        cyc();
        chk("lost_flag", 32'(lost), 1);
        chk("lost_en_l", 32'(en_l), 0);
        chk("lost_en_r", 32'(en_r), 0);
        lost_phase = m_phase;
        repeat (30) cyc();
        chk("lost_frozen", 32'(phase), lost_phase);

        // manual key out of LOST
        man_r = 1'b1;
        repeat (2) cyc();
        chk("man_wait", 32'(state), 3);
        cyc();
        chk("man_track", 32'(state), 1);
        cyc();
        chk("man_en_r", 32'(en_r), 1);
        chk("man_en_l", 32'(en_l), 0);
        man_r = 1'b0;

        // reacquire on the very cycle the step count reaches its limit
        found = 0;
        for (int i = 1; i <= 400 && found == 0; i++) begin
            cyc();
            if (m_state == 2 && m_steps == 6 && m_due == m_n + 1) found = 1;
        end
        chk("reacq_setup", found, 1);
        beam_r = 1'b1;
        saw_lost = 0;
        for (int i = 1; i <= 7; i++) begin
            cyc();
            if (state == 2'd3) saw_lost = 1;
            if (i == 6) chk("reacq_hold", 32'(state), 2);
        end
        chk("reacq_track", 32'(state), 1);
        chk("reacq_nolost", saw_lost, 0);
        pp = phase; gap = 0;
        for (int i = 1; i <= 40 && gap == 0; i++) begin
            cyc();
            if (phase != pp) gap = i;
        end
        chk("reacq_gap", gap, 17);

        // right-side search, then reset mid-SEARCH
        beam_r = 1'b0;
        found = 0;
        for (int i = 1; i <= 30 && found == 0; i++) begin
            cyc();
            if (m_state == 2) found = 1;
        end
        chk("search2_entry", found, 1);
        cyc();
        chk("search2_dir_l", 32'(dir_l), 1);
        chk("search2_dir_r", 32'(dir_r), 0);
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        chk_reset_vals("midrst");
        reset = 1'b0;

        // 3-cycle glitch must be rejected, a held beam accepted
        repeat (5) cyc();
        beam_l = 1'b1;
        repeat (3) cyc();
        beam_l = 1'b0;
        repeat (10) cyc();
        chk("glitch_state", 32'(state), 0);
        chk("glitch_en_l", 32'(en_l), 0);
        beam_l = 1'b1;
        repeat (6) cyc();
        chk("held_idle", 32'(state), 0);
        cyc();
        chk("held_track", 32'(state), 1);
        cyc();
        chk("held_en_l", 32'(en_l), 1);
        chk("held_en_r", 32'(en_r), 0);

        // random inputs at varying toggle rates
        for (int seg = 0; seg < 6; seg++) begin
            rate = $urandom_range(4, 60);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, rate - 1) == 0) beam_l = ~beam_l;
                if ($urandom_range(0, rate - 1) == 0) beam_r = ~beam_r;
                if ($urandom_range(0, 8 * rate) == 0) man_l = ~man_l;
                if ($urandom_range(0, 8 * rate) == 0) man_r = ~man_r;
                reset = ($urandom_range(0, 799) == 0);
                cyc();
            end
            reset = 1'b0;
            beam_l = 1'b0; beam_r = 1'b0; man_l = 1'b0; man_r = 1'b0;
            repeat (150) cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
